// File: rtl/esp_sig_event_capture.sv
// ESP signal conditioner: synchroniser, glitch filter, edge timestamping, event FIFO.
// Define ESP_TRIG_DELAY_EN to build the delayed trigger pulse on trig_out.
module esp_sig_event_capture #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4,
  parameter int TS_WIDTH    = 32,
  parameter int FIFO_DEPTH  = 8,
  parameter int DELAY_WIDTH = 16
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   esp_sig_in,
  input  logic                   enable_in,
  input  logic                   evt_ready_in,
  output logic                   evt_valid_out,
  output logic [TS_WIDTH-1:0]    evt_ts_out,
  output logic                   evt_rise_out,
  output logic                   sig_level_out,
  output logic                   overflow_out,
  input  logic                   clear_ovf_in,
  input  logic [DELAY_WIDTH-1:0] trig_delay_in,
  output logic                   trig_out
);

  localparam int FC_W = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [FC_W-1:0]        r_fc;
  logic                   r_level;
  logic                   r_flip;
  logic [TS_WIDTH-1:0]    r_ts;
  logic [TS_WIDTH:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]          r_wr;
  logic [AW-1:0]          r_rd;
  logic [CW-1:0]          r_cnt;
  logic                   r_ovf;

  logic w_s;
  logic w_flip;
  logic w_push;
  logic w_full;
  logic w_valid;
  logic w_pop;
  logic w_wr;
  logic w_drop;

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_flip = (w_s != r_level) &&
                  (r_fc == FC_W'(FILT_CYCLES - 1));

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], esp_sig_in};
    end
  end

  // r_flip marks the first cycle the new level is visible; the event is
  // stamped and queued in that cycle
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_level <= 1'b0;
      r_fc    <= '0;
      r_flip  <= 1'b0;
    end else begin
      r_flip <= w_flip;
      if (w_s == r_level) begin
        r_fc <= '0;
      end else if (w_flip) begin
        r_level <= ~r_level;
        r_fc    <= '0;
      end else begin
        r_fc <= r_fc + FC_W'(1);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_ts <= '0;
    end else begin
      r_ts <= r_ts + TS_WIDTH'(1);
    end
  end

  assign w_push  = r_flip && enable_in;
  assign w_full  = (r_cnt == CW'(FIFO_DEPTH));
  assign w_valid = (r_cnt != '0);
  assign w_pop   = w_valid && evt_ready_in;
  assign w_wr    = w_push && (!w_full || w_pop);
  assign w_drop  = w_push && w_full && !w_pop;

  always_ff @(posedge clk_in) begin
    if (w_wr) begin
      r_mem[r_wr] <= {r_ts, r_level};
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) begin
        r_wr <= r_wr + AW'(1);
      end
      if (w_pop) begin
        r_rd <= r_rd + AW'(1);
      end
      if (w_wr && !w_pop) begin
        r_cnt <= r_cnt + CW'(1);
      end else if (!w_wr && w_pop) begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

  // a drop in the same cycle as a clear keeps the flag set
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (clear_ovf_in) begin
      r_ovf <= 1'b0;
    end
  end

  assign evt_valid_out = w_valid;
  assign evt_ts_out    = w_valid ? r_mem[r_rd][TS_WIDTH:1] : '0;
  assign evt_rise_out  = w_valid & r_mem[r_rd][0];
  assign sig_level_out = r_level;
  assign overflow_out  = r_ovf;

`ifdef ESP_TRIG_DELAY_EN
  logic [DELAY_WIDTH-1:0] r_dc;
  logic                   r_arm;
  logic                   w_load;

  assign w_load = r_flip && r_level && enable_in;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_dc  <= '0;
      r_arm <= 1'b0;
    end else if (w_load) begin
      r_dc  <= trig_delay_in;
      r_arm <= 1'b1;
    end else if (r_arm) begin
      if (r_dc == '0) begin
        r_arm <= 1'b0;
      end else begin
        r_dc <= r_dc - DELAY_WIDTH'(1);
      end
    end
  end

  assign trig_out = r_arm && (r_dc == '0);
`else
  logic w_unused_dly;

  assign w_unused_dly = ^trig_delay_in;
  assign trig_out     = 1'b0;
`endif

endmodule
